// File: rtl/reg_rename_file_pkg.sv
// rtl/reg_rename_file_pkg.sv - shared widths, bus types and constants for the rename register file
package reg_rename_file_pkg;

    localparam int RRF_XLEN   = 32;
    localparam int RRF_NREG   = 32;
    localparam int RRF_TAG_W  = 4;
    localparam int RRF_NAME_W = $clog2(RRF_NREG);

    typedef logic [RRF_NAME_W-1:0] name_bus_t;
    typedef logic [RRF_TAG_W-1:0]  tag_bus_t;
    typedef logic [RRF_XLEN-1:0]   data_bus_t;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam logic VALID   = 1'b1;
    localparam logic INVALID = 1'b0;

    localparam name_bus_t NULL_NAME = '0;
    localparam tag_bus_t  NULL_TAG  = '0;
    localparam data_bus_t NULL_DATA = '0;

    // x0 is hardwired to zero, so only non-zero names carry state
    function automatic logic is_live_name(input logic [RRF_NAME_W-1:0] name);
        return (name != NULL_NAME) ? VALID : INVALID;
    endfunction

endpackage

// File: rtl/reg_rename_file_rrf_read_port.sv
// rtl/reg_rename_file_rrf_read_port.sv - one dispatch read port: operand mux plus optional commit bypass (COMMIT_BYPASS_EN)
module rrf_read_port
    import reg_rename_file_pkg::*;
#(
    parameter int XLEN   = RRF_XLEN,
    parameter int NREG   = RRF_NREG,
    parameter int TAG_W  = RRF_TAG_W,
    parameter int NAME_W = $clog2(NREG)
) (
    input  logic                       re,
    input  logic [NAME_W-1:0]          addr,
    input  logic [NREG-1:0]            busy_q,
    input  logic [NREG-1:0][TAG_W-1:0] tag_q,
    input  logic [NREG-1:0][XLEN-1:0]  data_q,
    input  logic                       commit_en,
    input  logic [NAME_W-1:0]          commit_addr,
    input  logic [TAG_W-1:0]           commit_tag,
    input  logic [XLEN-1:0]            commit_data,
    output logic                       busy,
    output logic [TAG_W-1:0]           tag,
    output logic [XLEN-1:0]            data
);

    logic              live;
    logic              sel_busy;
    logic [TAG_W-1:0]  sel_tag;
    logic [XLEN-1:0]   sel_data;

    assign live     = re && (addr != '0);
    assign sel_busy = busy_q[addr];
    assign sel_tag  = tag_q[addr];
    assign sel_data = data_q[addr];

`ifdef COMMIT_BYPASS_EN
    logic bypass_hit;

    // forward a retiring producer so dispatch need not wait for the next edge
    assign bypass_hit = live && sel_busy && commit_en &&
                        (commit_addr == addr) && (commit_tag == sel_tag);

    always_comb begin
        busy = DISABLE;
        tag  = '0;
        data = '0;
        if (live == VALID) begin
            tag = sel_tag;
            if (bypass_hit) begin
                busy = DISABLE;
                data = commit_data;
            end else begin
                busy = sel_busy;
                data = sel_data;
            end
        end
    end
`else
    logic                unused_commit;
    assign unused_commit = commit_en ^ (^commit_addr) ^ (^commit_tag) ^ (^commit_data);

    always_comb begin
        busy = DISABLE;
        tag  = '0;
        data = '0;
        if (live == VALID) begin
            busy = sel_busy;
            tag  = sel_tag;
            data = sel_data;
        end
    end
`endif

endmodule

// File: rtl/reg_rename_file.sv
// rtl/reg_rename_file.sv - architectural register file with busy/ROB-tag rename status; COMMIT_BYPASS_EN enables same-cycle commit forwarding
module reg_rename_file
    import reg_rename_file_pkg::*;
#(
    parameter int XLEN   = RRF_XLEN,
    parameter int NREG   = RRF_NREG,
    parameter int TAG_W  = RRF_TAG_W,
    parameter int NAME_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              rename_en,
    input  logic [NAME_W-1:0] rename_addr,
    input  logic [TAG_W-1:0]  rename_tag,
    input  logic              commit_en,
    input  logic [NAME_W-1:0] commit_addr,
    input  logic [TAG_W-1:0]  commit_tag,
    input  logic [XLEN-1:0]   commit_data,
    input  logic              reg1_re,
    input  logic [NAME_W-1:0] reg1_addr,
    output logic              reg1_busy,
    output logic [TAG_W-1:0]  reg1_tag,
    output logic [XLEN-1:0]   reg1_data,
    input  logic              reg2_re,
    input  logic [NAME_W-1:0] reg2_addr,
    output logic              reg2_busy,
    output logic [TAG_W-1:0]  reg2_tag,
    output logic [XLEN-1:0]   reg2_data
);

    logic [NREG-1:0]            busy_q;
    logic [NREG-1:0][TAG_W-1:0] tag_q;
    logic [NREG-1:0][XLEN-1:0]  data_q;

    logic commit_live;
    logic commit_current;
    logic rename_live;

    assign commit_live    = commit_en && (is_live_name(commit_addr) == VALID);
    assign commit_current = busy_q[commit_addr] && (tag_q[commit_addr] == commit_tag);
    assign rename_live    = rename_en && !clear && (is_live_name(rename_addr) == VALID);

    // commit, then clear, then rename: later non-blocking writes override earlier ones
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            tag_q  <= '0;
            data_q <= '0;
        end else if (rdy) begin
            if (commit_live) begin
                data_q[commit_addr] <= commit_data;
                if (commit_current) begin
                    busy_q[commit_addr] <= DISABLE;
                end
            end
            if (clear) begin
                busy_q <= '0;
            end
            if (rename_live) begin
                busy_q[rename_addr] <= ENABLE;
                tag_q[rename_addr]  <= rename_tag;
            end
        end
    end

    rrf_read_port #(
        .XLEN   (XLEN),
        .NREG   (NREG),
        .TAG_W  (TAG_W),
        .NAME_W (NAME_W)
    ) u_read1 (
        .re          (reg1_re),
        .addr        (reg1_addr),
        .busy_q      (busy_q),
        .tag_q       (tag_q),
        .data_q      (data_q),
        .commit_en   (commit_en),
        .commit_addr (commit_addr),
        .commit_tag  (commit_tag),
        .commit_data (commit_data),
        .busy        (reg1_busy),
        .tag         (reg1_tag),
        .data        (reg1_data)
    );

    rrf_read_port #(
        .XLEN   (XLEN),
        .NREG   (NREG),
        .TAG_W  (TAG_W),
        .NAME_W (NAME_W)
    ) u_read2 (
        .re          (reg2_re),
        .addr        (reg2_addr),
        .busy_q      (busy_q),
        .tag_q       (tag_q),
        .data_q      (data_q),
        .commit_en   (commit_en),
        .commit_addr (commit_addr),
        .commit_tag  (commit_tag),
        .commit_data (commit_data),
        .busy        (reg2_busy),
        .tag         (reg2_tag),
        .data        (reg2_data)
    );

endmodule

// File: tb/tb_reg_rename_file.sv
// tb/tb_reg_rename_file.sv - directed and randomized checks of reg_rename_file against a register-level model
module tb_reg_rename_file;

    logic        clk = 1'b0;
    logic        rst, rdy, clear;
    logic        rename_en, commit_en;
    logic [4:0]  rename_addr, commit_addr;
    logic [3:0]  rename_tag, commit_tag;
    logic [31:0] commit_data;
    logic        reg1_re, reg2_re;
    logic [4:0]  reg1_addr, reg2_addr;
    logic        reg1_busy, reg2_busy;
    logic [3:0]  reg1_tag, reg2_tag;
    logic [31:0] reg1_data, reg2_data;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_data [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];

    always #5 clk = ~clk;

    reg_rename_file dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .rename_en(rename_en), .rename_addr(rename_addr), .rename_tag(rename_tag),
        .commit_en(commit_en), .commit_addr(commit_addr), .commit_tag(commit_tag),
        .commit_data(commit_data),
        .reg1_re(reg1_re), .reg1_addr(reg1_addr), .reg1_busy(reg1_busy),
        .reg1_tag(reg1_tag), .reg1_data(reg1_data),
        .reg2_re(reg2_re), .reg2_addr(reg2_addr), .reg2_busy(reg2_busy),
        .reg2_tag(reg2_tag), .reg2_data(reg2_data)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic expect_read(input logic re, input logic [4:0] a,
                               output logic b, output logic [3:0] t, output logic [31:0] d);
        b = 1'b0; t = 4'd0; d = 32'd0;
        if (re && a != 5'd0) begin
            b = m_busy[a]; t = m_tag[a]; d = m_data[a];
`ifdef COMMIT_BYPASS_EN
            if (m_busy[a] && commit_en && commit_addr == a && commit_tag == m_tag[a]) begin
                b = 1'b0; d = commit_data;
            end
`endif
        end
    endtask

    task automatic check_model();
        logic b; logic [3:0] t; logic [31:0] d;
        expect_read(reg1_re, reg1_addr, b, t, d);
        chk("p1_busy", {31'd0, reg1_busy}, {31'd0, b});
        chk("p1_tag",  {28'd0, reg1_tag},  {28'd0, t});
        chk("p1_data", reg1_data, d);
        expect_read(reg2_re, reg2_addr, b, t, d);
        chk("p2_busy", {31'd0, reg2_busy}, {31'd0, b});
        chk("p2_tag",  {28'd0, reg2_tag},  {28'd0, t});
        chk("p2_data", reg2_data, d);
    endtask

    task automatic update_model();
        logic cm, rn, rel;
        for (int r = 0; r < 32; r++) begin
            if (rst) begin
                m_data[r] = 32'd0; m_busy[r] = 1'b0; m_tag[r] = 4'd0;
            end else if (rdy && r != 0) begin
                cm  = commit_en && commit_addr == 5'(r);
                rn  = rename_en && !clear && rename_addr == 5'(r);
                rel = cm && m_busy[r] && m_tag[r] == commit_tag;
                if (cm) m_data[r] = commit_data;
                if (rn) begin
                    m_busy[r] = 1'b1; m_tag[r] = rename_tag;
                end else if (clear || rel) begin
                    m_busy[r] = 1'b0;
                end
            end
        end
    endtask

    task automatic cycle();
        #1;
        check_model();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic idle();
        rdy = 1'b1; clear = 1'b0; rename_en = 1'b0; commit_en = 1'b0;
        rename_addr = 5'd0; rename_tag = 4'd0;
        commit_addr = 5'd0; commit_tag = 4'd0; commit_data = 32'd0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        reg1_re = 1'b1; reg1_addr = a1;
        reg2_re = 1'b1; reg2_addr = a2;
        #1;
    endtask

    task automatic do_rename(input logic [4:0] a, input logic [3:0] t);
        idle(); rename_en = 1'b1; rename_addr = a; rename_tag = t;
        cycle(); idle();
    endtask

    task automatic do_commit(input logic [4:0] a, input logic [3:0] t, input logic [31:0] d);
        idle(); commit_en = 1'b1; commit_addr = a; commit_tag = t; commit_data = d;
        cycle(); idle();
    endtask

    initial begin
        idle();
        rst = 1'b1; reg1_re = 1'b0; reg2_re = 1'b0; reg1_addr = 5'd0; reg2_addr = 5'd0;
        for (int i = 0; i < 32; i++) begin
            m_data[i] = 32'hdead_beef; m_busy[i] = 1'b1; m_tag[i] = 4'hf;
        end
        @(negedge clk);
        @(posedge clk); update_model(); @(negedge clk);
        @(posedge clk); update_model(); @(negedge clk);
        rst = 1'b0;

        // reset state and x0
        rd(5'd5, 5'd0);
        chk("rst_busy", {31'd0, reg1_busy}, 32'd0);
        chk("rst_tag",  {28'd0, reg1_tag},  32'd0);
        chk("rst_data", reg1_data, 32'd0);
        do_commit(5'd0, 4'd0, 32'hff);
        rd(5'd0, 5'd0);
        chk("x0_data", reg1_data, 32'd0);
        chk("x0_busy", {31'd0, reg1_busy}, 32'd0);

        // rename then matching commit
        do_rename(5'd3, 4'd2);
        rd(5'd3, 5'd3);
        chk("ren_busy", {31'd0, reg1_busy}, 32'd1);
        chk("ren_tag",  {28'd0, reg2_tag},  32'd2);
        do_commit(5'd3, 4'd2, 32'h1234);
        rd(5'd3, 5'd3);
        chk("cmt_busy", {31'd0, reg1_busy}, 32'd0);
        chk("cmt_data", reg2_data, 32'h1234);

        // stale commit keeps the newer rename
        do_rename(5'd4, 4'd1);
        do_rename(5'd4, 4'd5);
        do_commit(5'd4, 4'd1, 32'd7);
        rd(5'd4, 5'd4);
        chk("stale_data", reg1_data, 32'd7);
        chk("stale_busy", {31'd0, reg1_busy}, 32'd1);
        chk("stale_tag",  {28'd0, reg1_tag},  32'd5);
        do_commit(5'd4, 4'd5, 32'd8);
        rd(5'd4, 5'd4);
        chk("cur_busy", {31'd0, reg1_busy}, 32'd0);

        // same-cycle commit and rename on one register
        do_rename(5'd6, 4'd3);
        idle();
        commit_en = 1'b1; commit_addr = 5'd6; commit_tag = 4'd3; commit_data = 32'd9;
        rename_en = 1'b1; rename_addr = 5'd6; rename_tag = 4'd8;
        cycle(); idle();
        rd(5'd6, 5'd6);
        chk("both_data", reg1_data, 32'd9);
        chk("both_busy", {31'd0, reg1_busy}, 32'd1);
        chk("both_tag",  {28'd0, reg1_tag},  32'd8);

        // clear with commit and a suppressed rename
        do_rename(5'd1, 4'd10);
        do_rename(5'd2, 4'd11);
        idle();
        clear = 1'b1;
        commit_en = 1'b1; commit_addr = 5'd1; commit_tag = 4'd10; commit_data = 32'ha;
        rename_en = 1'b1; rename_addr = 5'd7; rename_tag = 4'd12;
        cycle(); idle();
        rd(5'd1, 5'd2);
        chk("clr_x1_busy", {31'd0, reg1_busy}, 32'd0);
        chk("clr_x1_data", reg1_data, 32'ha);
        chk("clr_x2_busy", {31'd0, reg2_busy}, 32'd0);
        chk("clr_x6_busy", 32'(m_busy[6]), 32'd0);
        rd(5'd7, 5'd6);
        chk("clr_x7_busy", {31'd0, reg1_busy}, 32'd0);
        chk("clr_x6_dut",  {31'd0, reg2_busy}, 32'd0);

        // commit-cycle read of a busy register
        do_rename(5'd3, 4'd6);
        idle();
        commit_en = 1'b1; commit_addr = 5'd3; commit_tag = 4'd6; commit_data = 32'h55;
        rd(5'd3, 5'd0);
`ifdef COMMIT_BYPASS_EN
        chk("byp_busy", {31'd0, reg1_busy}, 32'd0);
        chk("byp_data", reg1_data, 32'h55);
`else
        chk("nobyp_busy", {31'd0, reg1_busy}, 32'd1);
        chk("nobyp_tag",  {28'd0, reg1_tag},  32'd6);
`endif
        cycle(); idle();

        // rdy=0 holds everything
        rdy = 1'b0;
        rename_en = 1'b1; rename_addr = 5'd8; rename_tag = 4'd2;
        commit_en = 1'b1; commit_addr = 5'd3; commit_tag = 4'd6; commit_data = 32'h77;
        cycle(); idle();
        rd(5'd8, 5'd3);
        chk("hold_busy", {31'd0, reg1_busy}, 32'd0);
        chk("hold_data", reg2_data, 32'h55);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            idle();
            rdy         = ($urandom_range(0, 9) != 0);
            clear       = ($urandom_range(0, 29) == 0);
            rename_en   = $urandom_range(0, 1) == 1;
            rename_addr = 5'($urandom_range(0, 7));
            rename_tag  = 4'($urandom);
            commit_en   = $urandom_range(0, 1) == 1;
            commit_addr = 5'($urandom_range(0, 7));
            commit_tag  = ($urandom_range(0, 2) != 0) ? m_tag[commit_addr] : 4'($urandom);
            commit_data = $urandom;
            reg1_re     = $urandom_range(0, 3) != 0;
            reg1_addr   = ($urandom_range(0, 1) == 1) ? commit_addr : 5'($urandom_range(0, 7));
            reg2_re     = $urandom_range(0, 3) != 0;
            reg2_addr   = ($urandom_range(0, 1) == 1) ? rename_addr : 5'($urandom_range(0, 7));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
